// File: rtl/barrel_shift_arbiter.sv
// Two-requester arbiter feeding a 4-bit rotate-right unit, with a three-state
// accept / rotate / hold-result handshake and a fairness pointer.
module barrel_shift_arbiter #(
  parameter int RESET_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0Valid,
  input  logic       req1Valid,
  input  logic [3:0] req0Data,
  input  logic [3:0] req1Data,
  input  logic [1:0] req0Amount,
  input  logic [1:0] req1Amount,
  output logic       req0Ready,
  output logic       req1Ready,
  output logic       resValid,
  output logic [3:0] resData,
  output logic       resSource,
  input  logic       resReady,
  output logic       busy
);

  localparam int DATA_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROTATE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]        state;
  logic              prio;
  logic              grant;
  logic              grant_src;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_amt;

  logic [DATA_W-1:0] cap_data_p0;
  logic [1:0]        cap_amt_p0;
  logic              cap_src_p0;
  logic [DATA_W-1:0] res_data_p1;
  logic              res_src_p1;

  // result[i] = d[(i + amt) mod 4]
  function automatic logic [DATA_W-1:0] rotate_right(input logic [DATA_W-1:0] d,
                                                     input logic [1:0] amt);
    logic [DATA_W-1:0] r;
    case (amt)
      2'd1:    r = {d[0], d[3:1]};
      2'd2:    r = {d[1:0], d[3:2]};
      2'd3:    r = {d[2:0], d[3]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Grant is combinational so ready is seen in the accept cycle itself.
  always_comb begin
    grant     = 1'b0;
    grant_src = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0Valid && req1Valid) begin
        grant     = 1'b1;
        grant_src = prio;
      end else if (req0Valid) begin
        grant     = 1'b1;
        grant_src = 1'b0;
      end else if (req1Valid) begin
        grant     = 1'b1;
        grant_src = 1'b1;
      end
    end
  end

  assign req0Ready = grant && !grant_src;
  assign req1Ready = grant && grant_src;
  assign sel_data  = grant_src ? req1Data : req0Data;
  assign sel_amt   = grant_src ? req1Amount : req0Amount;

  // Stage p0: capture the granted operand.
  always_ff @(posedge clk) begin
    if (grant) begin
      cap_data_p0 <= sel_data;
      cap_amt_p0  <= sel_amt;
      cap_src_p0  <= grant_src;
    end
  end

  // Stage p1: rotated result plus control; result is frozen while in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= (RESET_PRIORITY != 0);
      res_data_p1 <= '0;
      res_src_p1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) state <= ROTATE;
        end
        ROTATE: begin
          res_data_p1 <= rotate_right(cap_data_p0, cap_amt_p0);
          res_src_p1  <= cap_src_p0;
          state       <= HOLD;
        end
        HOLD: begin
          if (resReady) begin
            prio  <= ~res_src_p1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resValid  = (state == HOLD);
  assign resData   = res_data_p1;
  assign resSource = res_src_p1;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench for barrel_shift_arbiter; a second instance with
// RESET_PRIORITY = 1 shares the stimulus to check the reset priority choice.
module tb_barrel_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0Valid, req1Valid;
  logic [3:0] req0Data, req1Data;
  logic [1:0] req0Amount, req1Amount;
  logic       resReady;

  logic       req0Ready, req1Ready, resValid, resSource, busy;
  logic [3:0] resData;
  logic       req0Ready_b, req1Ready_b, resValid_b, resSource_b, busy_b;
  logic [3:0] resData_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  barrel_shift_arbiter #(.RESET_PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Data(req0Data), .req1Data(req1Data),
    .req0Amount(req0Amount), .req1Amount(req1Amount),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .resValid(resValid), .resData(resData), .resSource(resSource),
    .resReady(resReady), .busy(busy)
  );

  barrel_shift_arbiter #(.RESET_PRIORITY(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Data(req0Data), .req1Data(req1Data),
    .req0Amount(req0Amount), .req1Amount(req1Amount),
    .req0Ready(req0Ready_b), .req1Ready(req1Ready_b),
    .resValid(resValid_b), .resData(resData_b), .resSource(resSource_b),
    .resReady(resReady), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] amt_exp [4];
    logic       src_exp;
    amt_exp[0] = 4'b0001; amt_exp[1] = 4'b1000;
    amt_exp[2] = 4'b0100; amt_exp[3] = 4'b0010;

    // Reset values, with a requester already asking.
    rst_n = 1'b0; req0Valid = 1'b1; req1Valid = 1'b0;
    req0Data = 4'h0; req1Data = 4'h0; req0Amount = 2'd0; req1Amount = 2'd0;
    resReady = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready0", {7'd0, req0Ready}, 8'd0);
    chk("rst_ready1", {7'd0, req1Ready}, 8'd0);
    chk("rst_valid", {7'd0, resValid}, 8'd0);
    chk("rst_data", {4'd0, resData}, 8'd0);
    chk("rst_source", {7'd0, resSource}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ready0_b", {7'd0, req0Ready_b}, 8'd0);
    @(negedge clk);
    req0Valid = 1'b0; rst_n = 1'b1;

    // Single requester 0, 1001 rotated by 1.
    @(negedge clk);
    req0Valid = 1'b1; req0Data = 4'b1001; req0Amount = 2'd1; resReady = 1'b1;
    #1;
    chk("single_ready0", {7'd0, req0Ready}, 8'd1);
    chk("single_ready1", {7'd0, req1Ready}, 8'd0);
    chk("single_busy_idle", {7'd0, busy}, 8'd0);
    @(negedge clk);
    req0Valid = 1'b0; req0Data = 4'hF; req0Amount = 2'd3;
    #1;
    chk("single_busy_rot", {7'd0, busy}, 8'd1);
    chk("single_valid_rot", {7'd0, resValid}, 8'd0);
    @(negedge clk); #1;
    chk("single_valid", {7'd0, resValid}, 8'd1);
    chk("single_data", {4'd0, resData}, 8'h0C);
    chk("single_source", {7'd0, resSource}, 8'd0);
    @(negedge clk); #1;
    chk("single_done_valid", {7'd0, resValid}, 8'd0);
    chk("single_done_busy", {7'd0, busy}, 8'd0);

    // Fresh reset, then continuous contention: grants alternate 0,1,0,1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0Valid = 1'b1; req0Data = 4'b0011; req0Amount = 2'd1;
    req1Valid = 1'b1; req1Data = 4'b0100; req1Amount = 2'd2;
    resReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src_exp = (k % 2) == 1;
      #1;
      chk("alt_ready0", {7'd0, req0Ready}, {7'd0, !src_exp});
      chk("alt_ready1", {7'd0, req1Ready}, {7'd0, src_exp});
      if (k == 0) begin
        chk("prio1_ready1", {7'd0, req1Ready_b}, 8'd1);
        chk("prio1_ready0", {7'd0, req0Ready_b}, 8'd0);
      end
      @(negedge clk); #1;
      chk("alt_hold_ready", {6'd0, req0Ready, req1Ready}, 8'd0);
      chk("alt_busy", {7'd0, busy}, 8'd1);
      @(negedge clk); #1;
      chk("alt_valid", {7'd0, resValid}, 8'd1);
      chk("alt_source", {7'd0, resSource}, {7'd0, src_exp});
      chk("alt_data", {4'd0, resData}, src_exp ? 8'h01 : 8'h09);
      @(negedge clk);
    end
    req0Valid = 1'b0; req1Valid = 1'b0;

    // Rotate amounts 0..3 on 0001.
    for (int a = 0; a < 4; a++) begin
      req0Valid = 1'b1; req0Data = 4'b0001; req0Amount = 2'(a);
      #1;
      chk("amt_ready0", {7'd0, req0Ready}, 8'd1);
      @(negedge clk);
      req0Valid = 1'b0;
      #1;
      chk("amt_valid_rot", {7'd0, resValid}, 8'd0);
      @(negedge clk); #1;
      chk("amt_valid", {7'd0, resValid}, 8'd1);
      chk("amt_data", {4'd0, resData}, {4'd0, amt_exp[a]});
      @(negedge clk);
    end

    // Backpressure: result must hold while resReady stays low.
    req1Valid = 1'b1; req1Data = 4'b1010; req1Amount = 2'd3; resReady = 1'b0;
    #1;
    chk("bp_ready1", {7'd0, req1Ready}, 8'd1);
    @(negedge clk);
    req0Valid = 1'b1; req1Valid = 1'b1; req0Data = 4'hE; req1Data = 4'h3;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", {7'd0, resValid}, 8'd1);
      chk("bp_data", {4'd0, resData}, 8'h05);
      chk("bp_source", {7'd0, resSource}, 8'd1);
      chk("bp_ready", {6'd0, req0Ready, req1Ready}, 8'd0);
      chk("bp_busy", {7'd0, busy}, 8'd1);
      @(negedge clk);
    end
    req0Valid = 1'b0; req1Valid = 1'b0; req1Data = 4'b1010; resReady = 1'b1;
    #1;
    chk("bp_last_valid", {7'd0, resValid}, 8'd1);
    @(negedge clk); #1;
    chk("bp_done_valid", {7'd0, resValid}, 8'd0);
    chk("bp_done_busy", {7'd0, busy}, 8'd0);

    // Reset during ROTATE aborts the operation.
    @(negedge clk);
    req0Valid = 1'b1; req0Data = 4'b0111; req0Amount = 2'd2;
    #1;
    chk("abort_ready0", {7'd0, req0Ready}, 8'd1);
    @(negedge clk);
    req0Valid = 1'b0;
    #1;
    chk("abort_busy_rot", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {7'd0, resValid}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_data", {4'd0, resData}, 8'd0);
    chk("abort_source", {7'd0, resSource}, 8'd0);
    @(negedge clk); #1;
    chk("abort_valid_hold", {7'd0, resValid}, 8'd0);
    rst_n = 1'b1; req1Valid = 1'b1;
    #1;
    chk("abort_ready1", {7'd0, req1Ready}, 8'd1);
    chk("abort_ready0_after", {7'd0, req0Ready}, 8'd0);
    @(negedge clk);
    req1Valid = 1'b0;
    #1;
    chk("abort_valid_rot2", {7'd0, resValid}, 8'd0);
    @(negedge clk); #1;
    chk("abort_res_valid", {7'd0, resValid}, 8'd1);
    chk("abort_res_source", {7'd0, resSource}, 8'd1);
    chk("abort_res_data", {4'd0, resData}, 8'h05);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
